// File: rtl/parity_frame_serializer_if.sv
// Handshake and serial-stream bundle for parity_frame_serializer.
// master = word producer / stream observer, slave = serializer.
interface parity_frame_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             valid;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             parity_slot;

  modport master (
    output data_in, valid,
    input  ready, sout, sout_valid, frame_start, parity_slot
  );

  modport slave (
    input  data_in, valid,
    output ready, sout, sout_valid, frame_start, parity_slot
  );
endinterface

// File: rtl/parity_frame_serializer.sv
// Parallel-to-serial LSB-first framer appending one parity bit per word; 1-cycle accept-to-bit0 latency.
// Backpressure: ready low while data bits shift. Macro PARITY_FRAME_ODD_PARITY_EN selects odd parity.
module parity_frame_serializer #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  parity_frame_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PARITY_FRAME_ODD_PARITY_EN
  localparam logic PAR_INV = 1'b1;
`else
  localparam logic PAR_INV = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             par;
  logic             accept;

  assign bus.ready = (state != DATA);
  assign accept    = bus.valid && bus.ready;

  // count tracks which data bit is currently on sout; bit 0 is driven on the accept edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      shreg           <= '0;
      count           <= '0;
      par             <= 1'b0;
      bus.sout        <= 1'b0;
      bus.sout_valid  <= 1'b0;
      bus.frame_start <= 1'b0;
      bus.parity_slot <= 1'b0;
    end else begin
      case (state)
        DATA: begin
          count           <= count + CW'(1);
          bus.frame_start <= 1'b0;
          bus.sout_valid  <= 1'b1;
          if (count == LAST) begin
            state           <= PARITY;
            bus.sout        <= par;
            bus.parity_slot <= 1'b1;
          end else begin
            bus.sout        <= shreg[0];
            shreg           <= shreg >> 1;
            bus.parity_slot <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            state           <= DATA;
            shreg           <= bus.data_in >> 1;
            count           <= '0;
            par             <= (^bus.data_in) ^ PAR_INV;
            bus.sout        <= bus.data_in[0];
            bus.sout_valid  <= 1'b1;
            bus.frame_start <= 1'b1;
            bus.parity_slot <= 1'b0;
          end else begin
            state           <= IDLE;
            bus.sout        <= 1'b0;
            bus.sout_valid  <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.parity_slot <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_parity_frame_serializer.sv
// Directed bench for parity_frame_serializer with a queue-based stream model and literal frame checks.
module tb_parity_frame_serializer;
  localparam int W = 8;

`ifdef PARITY_FRAME_ODD_PARITY_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  typedef struct packed {
    logic sout;
    logic vld;
    logic fs;
    logic ps;
  } item_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  parity_frame_serializer_if #(.WIDTH(W)) bus ();

  parity_frame_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue of wire items still to be shown after the current one.
  item_t cur = '0;
  item_t q[$];
  bit    model_on = 0;
  logic  run_par = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      cur = '0;
      model_on = 1;
    end else if (model_on) begin
      if (q.size() == 0 && bus.valid) begin
        for (int i = 0; i < W; i++)
          q.push_back('{sout: bus.data_in[i], vld: 1'b1, fs: (i == 0), ps: 1'b0});
        q.push_back('{sout: (^bus.data_in) ^ ODD, vld: 1'b1, fs: 1'b0, ps: 1'b1});
      end
      cur = (q.size() != 0) ? q.pop_front() : item_t'('0);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_sout",        bus.sout,        cur.sout);
      chk("m_sout_valid",  bus.sout_valid,  cur.vld);
      chk("m_frame_start", bus.frame_start, cur.fs);
      chk("m_parity_slot", bus.parity_slot, cur.ps);
      chk("m_ready",       bus.ready,       q.size() == 0);
      // downstream checker view: XOR of a whole frame must equal the parity sense
      if (bus.sout_valid)
        run_par = bus.frame_start ? bus.sout : (run_par ^ bus.sout);
      if (bus.sout_valid && bus.parity_slot)
        chk("checker_parity", run_par, ODD);
    end
  end

  // Offer a word in IDLE and compare the 9 wire bits against a hand-written literal.
  task automatic frame_check(input string nm, input logic [7:0] d, input logic [8:0] exp_bits);
    bus.valid   = 1'b1;
    bus.data_in = d;
    @(negedge clk);
    bus.valid = 1'b0;
    for (int k = 0; k <= W; k++) begin
      chk({nm, "_sout"}, bus.sout, exp_bits[k]);
      chk({nm, "_fs"}, bus.frame_start, (k == 0));
      chk({nm, "_ps"}, bus.parity_slot, (k == W));
      @(negedge clk);
    end
    chk({nm, "_idle_after"}, bus.sout_valid, 1'b0);
  endtask

  // Two words offered with valid held; second must ride the first's parity cycle.
  task automatic b2b(input string nm, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [17:0] exp_bits);
    int vcount;
    vcount = 0;
    bus.valid   = 1'b1;
    bus.data_in = d0;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (k == 0) bus.data_in = d1;
      if (k == W + 1) bus.valid = 1'b0;
      if (k < 18) chk({nm, "_bit"}, bus.sout, exp_bits[k]);
      if (k >= 1 && k < W) chk({nm, "_ready_low"}, bus.ready, 1'b0);
      if (bus.sout_valid) vcount++;
      @(negedge clk);
    end
    chk({nm, "_valid_cycles"}, vcount, 18);
  endtask

  initial begin
    bus.valid   = 1'b0;
    bus.data_in = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_sout", bus.sout, 1'b0);
    chk("rst_sout_valid", bus.sout_valid, 1'b0);
    chk("rst_frame_start", bus.frame_start, 1'b0);
    chk("rst_parity_slot", bus.parity_slot, 1'b0);
    chk("rst_ready", bus.ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);

    frame_check("a5", 8'hA5, ODD ? 9'h1A5 : 9'h0A5);
    frame_check("07", 8'h07, ODD ? 9'h007 : 9'h107);

    // 0x3C then 0xFF: both even weight
    b2b("b2b", 8'h3C, 8'hFF, ODD ? {1'b1, 8'hFF, 1'b1, 8'h3C} : {1'b0, 8'hFF, 1'b0, 8'h3C});
    // data_in changes to 0x22 while ready is low; frame 1 must still carry 0x11
    b2b("bp", 8'h11, 8'h22, ODD ? {1'b1, 8'h22, 1'b1, 8'h11} : {1'b0, 8'h22, 1'b0, 8'h11});

    // reset after four data bits of 0xF0
    bus.valid   = 1'b1;
    bus.data_in = 8'hF0;
    @(negedge clk);
    bus.valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("f0_low_bits", bus.sout, 1'b0);
      if (k < 3) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_sout_valid", bus.sout_valid, 1'b0);
    chk("midrst_sout", bus.sout, 1'b0);
    chk("midrst_frame_start", bus.frame_start, 1'b0);
    chk("midrst_parity_slot", bus.parity_slot, 1'b0);
    chk("midrst_ready", bus.ready, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("postrst_ready", bus.ready, 1'b1);
    frame_check("01", 8'h01, ODD ? 9'h001 : 9'h101);

    // reset and valid on the same edge: no frame may start
    reset       = 1'b1;
    bus.valid   = 1'b1;
    bus.data_in = 8'h55;
    @(negedge clk);
    reset     = 1'b0;
    bus.valid = 1'b0;
    chk("rstvld_sout_valid0", bus.sout_valid, 1'b0);
    @(negedge clk);
    chk("rstvld_sout_valid1", bus.sout_valid, 1'b0);
    chk("rstvld_ready", bus.ready, 1'b1);
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
